// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the CPU (default owner) and a debug/loader port
// Ports: clk/reset (async, active-high); cpu_* and dbg_* request/we/addr/wdata; dbg_halt freezes the CPU;
// cpu_gnt/dbg_gnt access completes at the edge; cpu_ce stalls the CPU; mem_* drive the memory;
// arb_status = {halted, owner==DBG, owner==CPU, dbg_waiting}.
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter int WAIT_MAX = 4,
  parameter int BURST_MAX = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  input  logic          dbg_halt,
  output logic          cpu_gnt,
  output logic          dbg_gnt,
  output logic          cpu_ce,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic [3:0]    arb_status
);
  localparam logic [0:0] OWN_CPU = 1'b0;
  localparam logic [0:0] OWN_DBG = 1'b1;
  localparam logic [2:0] WMAX = 3'(WAIT_MAX);
  localparam logic [2:0] BLIM = 3'(BURST_MAX - 1);
  logic [0:0] owner, owner_nxt;
  logic       halted, is_dbg, dbg_waiting, stay_dbg, take_dbg;
  logic [2:0] wait_cnt, wait_nxt, burst_cnt, burst_nxt;
  assign is_dbg      = owner == OWN_DBG;
  assign cpu_gnt     = !reset && !is_dbg && cpu_req && !halted;
  assign dbg_gnt     = !reset && is_dbg && dbg_req;
  assign mem_addr    = is_dbg ? dbg_addr : cpu_addr;
  assign mem_wdata   = is_dbg ? dbg_wdata : cpu_wdata;
  assign mem_we      = (cpu_gnt && cpu_we) || (dbg_gnt && dbg_we);
  assign cpu_ce      = !reset && !halted && !(cpu_req && !cpu_gnt);
  assign dbg_waiting = dbg_req && !dbg_gnt;
  assign arb_status  = {halted, is_dbg, !is_dbg, dbg_waiting};
  // burst limit only matters while the CPU is contending
  assign stay_dbg = is_dbg && dbg_req && (!cpu_req || burst_cnt < BLIM);
  assign take_dbg = dbg_req && (!cpu_req || wait_cnt == WMAX);
  always_comb begin
    owner_nxt = (dbg_halt || stay_dbg || take_dbg) ? OWN_DBG : OWN_CPU;
    burst_nxt = (!dbg_halt && stay_dbg) ? ((burst_cnt == 3'd7) ? 3'd7 : burst_cnt + 3'd1) : 3'd0;
    wait_nxt  = (dbg_gnt || !dbg_req) ? 3'd0 : ((wait_cnt == WMAX) ? WMAX : wait_cnt + 3'd1);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner     <= OWN_CPU;
      halted    <= 1'b0;
      wait_cnt  <= 3'd0;
      burst_cnt <= 3'd0;
    end else begin
      owner     <= owner_nxt;
      halted    <= dbg_halt;
      wait_cnt  <= wait_nxt;
      burst_cnt <= burst_nxt;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table, corner sequences and randomized reference-model checks
module tb_mem_arbiter;
  localparam int AW = 8, DW = 16, WAIT_MAX = 4, BURST_MAX = 2;
  logic clk = 0, reset = 1;
  logic cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0, dbg_halt = 0;
  logic [AW-1:0] cpu_addr = 8'h10, dbg_addr = 8'h20;
  logic [DW-1:0] cpu_wdata = 16'h1234, dbg_wdata = 16'hBEEF;
  logic cpu_gnt, dbg_gnt, cpu_ce, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0] arb_status;
  int n_pass = 0, n_tot = 0;
  mem_arbiter #(.AW(AW), .DW(DW), .WAIT_MAX(WAIT_MAX), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_halt(dbg_halt), .cpu_gnt(cpu_gnt), .dbg_gnt(dbg_gnt), .cpu_ce(cpu_ce),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .arb_status(arb_status)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic cr, cw, dr, dw, dh;
    logic cg, dg, we, ce;
    logic [3:0] st;
    logic [7:0] ad;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  task automatic add(input int n, input logic cr, cw, dr, dw, dh, cg, dg, we, ce,
                     input logic [3:0] st, input logic [7:0] ad);
    vec_t v;
    v = '{cr, cw, dr, dw, dh, cg, dg, we, ce, st, ad};
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask
  task automatic drive(input logic cr, cw, dr, dw, dh);
    cpu_req = cr; cpu_we = cw; dbg_req = dr; dbg_we = dw; dbg_halt = dh;
  endtask
  int m_own, m_halt, m_wait, m_burst;
  initial begin
    add(1, 1,0,0,0,0, 1,0,0,1, 4'b0010, 8'h10);
    add(5, 1,0,1,1,0, 1,0,0,1, 4'b0011, 8'h10);
    add(2, 1,0,1,1,0, 0,1,1,0, 4'b0100, 8'h20);
    add(1, 1,0,0,0,0, 1,0,0,1, 4'b0010, 8'h10);
    add(1, 1,0,0,0,1, 1,0,0,1, 4'b0010, 8'h10);
    add(5, 1,0,0,0,1, 0,0,0,0, 4'b1100, 8'h20);
    add(1, 1,0,0,0,0, 0,0,0,0, 4'b1100, 8'h20);
    add(1, 1,0,0,0,0, 1,0,0,1, 4'b0010, 8'h10);
    add(1, 1,1,0,0,0, 1,0,1,1, 4'b0010, 8'h10);
    add(1, 0,0,0,0,0, 0,0,0,1, 4'b0010, 8'h10);
    drive(1, 1, 1, 1, 0);
    repeat (2) @(negedge clk);
    #2;
    chk("reset cpu_gnt", 32'(cpu_gnt), 0);
    chk("reset dbg_gnt", 32'(dbg_gnt), 0);
    chk("reset mem_we", 32'(mem_we), 0);
    chk("reset cpu_ce", 32'(cpu_ce), 0);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset = 0;
      drive(tbl[i].cr, tbl[i].cw, tbl[i].dr, tbl[i].dw, tbl[i].dh);
      #2;
      chk($sformatf("vec%0d cpu_gnt", i), 32'(cpu_gnt), 32'(tbl[i].cg));
      chk($sformatf("vec%0d dbg_gnt", i), 32'(dbg_gnt), 32'(tbl[i].dg));
      chk($sformatf("vec%0d mem_we", i), 32'(mem_we), 32'(tbl[i].we));
      chk($sformatf("vec%0d cpu_ce", i), 32'(cpu_ce), 32'(tbl[i].ce));
      chk($sformatf("vec%0d status", i), 32'(arb_status), 32'(tbl[i].st));
      chk($sformatf("vec%0d mem_addr", i), 32'(mem_addr), 32'(tbl[i].ad));
      chk($sformatf("vec%0d mem_wdata", i), 32'(mem_wdata), (tbl[i].ad == 8'h20) ? 32'hBEEF : 32'h1234);
    end
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      drive(0, 0, c <= 10, 0, 0);
      #2;
      chk($sformatf("idle-cpu dbg_gnt c%0d", c), 32'(dbg_gnt), 32'(c >= 1 && c <= 10));
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 1, 1, 0);
    @(negedge clk);
    #2;
    chk("pre-reset dbg_gnt", 32'(dbg_gnt), 1);
    chk("pre-reset mem_we", 32'(mem_we), 1);
    #1 reset = 1;
    #1;
    chk("async reset mem_we", 32'(mem_we), 0);
    chk("async reset dbg_gnt", 32'(dbg_gnt), 0);
    chk("async reset cpu_ce", 32'(cpu_ce), 0);
    @(negedge clk);
    reset = 0;
    drive(1, 0, 0, 0, 0);
    #2;
    chk("post-reset cpu_gnt", 32'(cpu_gnt), 1);
    chk("post-reset status", 32'(arb_status), 4'b0010);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      drive(1, 0, 1, 0, 0);
      #2;
      chk($sformatf("post-reset latency c%0d", c), 32'(dbg_gnt), 32'(c == 5));
    end
    @(negedge clk);
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1;
    drive(1, 0, 0, 0, 1);
    @(negedge clk);
    reset = 0;
    #2;
    chk("halt-release cpu_gnt", 32'(cpu_gnt), 1);
    chk("halt-release cpu_ce", 32'(cpu_ce), 1);
    chk("halt-release status", 32'(arb_status), 4'b0010);
    @(negedge clk);
    #2;
    chk("halt-next cpu_ce", 32'(cpu_ce), 0);
    chk("halt-next status", 32'(arb_status), 4'b1100);
    dbg_halt = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    m_own = 0; m_halt = 0; m_wait = 0; m_burst = 0;
    for (int i = 0; i < 2000; i++) begin
      logic cg, dg, we, ce;
      logic [3:0] st;
      int n_own, n_burst;
      if (i > 0) @(negedge clk);
      drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 19) == 0);
      cpu_addr = 8'($urandom); dbg_addr = 8'($urandom);
      cpu_wdata = 16'($urandom); dbg_wdata = 16'($urandom);
      #2;
      cg = m_own == 0 && cpu_req && m_halt == 0;
      dg = m_own == 1 && dbg_req;
      we = (cg && cpu_we) || (dg && dbg_we);
      ce = m_halt == 0 && !(cpu_req && !cg);
      st = {m_halt == 1, m_own == 1, m_own == 0, dbg_req && !dg};
      chk($sformatf("rand%0d cpu_gnt", i), 32'(cpu_gnt), 32'(cg));
      chk($sformatf("rand%0d dbg_gnt", i), 32'(dbg_gnt), 32'(dg));
      chk($sformatf("rand%0d mem_we", i), 32'(mem_we), 32'(we));
      chk($sformatf("rand%0d cpu_ce", i), 32'(cpu_ce), 32'(ce));
      chk($sformatf("rand%0d status", i), 32'(arb_status), 32'(st));
      chk($sformatf("rand%0d mem_addr", i), 32'(mem_addr), 32'((m_own == 1) ? dbg_addr : cpu_addr));
      if (dbg_halt) begin
        n_own = 1; n_burst = 0;
      end else if (m_own == 1 && dbg_req && (!cpu_req || m_burst < BURST_MAX - 1)) begin
        n_own = 1; n_burst = (m_burst == 7) ? 7 : m_burst + 1;
      end else if (dbg_req && (!cpu_req || m_wait == WAIT_MAX)) begin
        n_own = 1; n_burst = 0;
      end else begin
        n_own = 0; n_burst = 0;
      end
      m_wait = (dg || !dbg_req) ? 0 : ((m_wait + 1 > WAIT_MAX) ? WAIT_MAX : m_wait + 1);
      m_halt = dbg_halt ? 1 : 0;
      m_own = n_own;
      m_burst = n_burst;
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Arbitrates the single-port program/data memory between two requesters: the CPU (control unit plus execution unit) and a debug/loader port.
- The CPU is the default owner and keeps zero-latency access.
- The debug port gets guaranteed access through a starvation counter, or exclusive access through a halt request.
- Sits between the CPU memory interface and the memory at the processor top level, and drives the CPU clock-enable that stalls the control unit, PC, IR and register file.

## Interface
Parameters:
- AW, 8: memory address width.
- DW, 16: memory data width.
- WAIT_MAX, 4: number of cycles debug may wait while the CPU holds the memory before it is forcibly granted; range 1–7.
- BURST_MAX, 2: maximum consecutive debug grant cycles while the CPU is requesting; range 1–7.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- cpu_req  in  1  CPU needs memory this cycle.
- cpu_we  in  1  CPU write strobe.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- dbg_req  in  1  debug needs memory this cycle.
- dbg_we  in  1  debug write strobe.
- dbg_addr  in  AW  debug address.
- dbg_wdata  in  DW  debug write data.
- dbg_halt  in  1  level request to freeze the CPU and give debug exclusive ownership.
- cpu_gnt  out  1  CPU access completes at this rising edge.
- dbg_gnt  out  1  debug access completes at this rising edge.
- cpu_ce  out  1  CPU clock-enable; 0 stalls all CPU state updates.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_we  out  1  memory write enable.
- arb_status  out  4  LED bits {halted, owner==DBG, owner==CPU, dbg_waiting}.

## Operation
- Registered state:
  - owner ∈ {CPU, DBG}
  - halted (1 bit)
  - wait_cnt (3 bits, saturating at WAIT_MAX)
  - burst_cnt (3 bits)
- Reset values: owner=CPU, halted=0, wait_cnt=0, burst_cnt=0.
- Grant logic (combinational from registered state):
  - cpu_gnt = owner==CPU & cpu_req & !halted.
  - dbg_gnt = owner==DBG & dbg_req.
  - While reset is high, cpu_gnt, dbg_gnt, mem_we and cpu_ce are 0.
- Memory mux:
  - mem_addr and mem_wdata come from the owner's inputs.
  - mem_we = (cpu_gnt & cpu_we) | (dbg_gnt & dbg_we).
  - mem_we is 0 when no grant is active.
- Clock-enable: cpu_ce = !halted & !(cpu_req & !cpu_gnt).
- Waiting flag: dbg_waiting = dbg_req & !dbg_gnt.
- Next owner is evaluated at each rising edge, in priority order:
  1. dbg_halt=1 → owner=DBG, halted=1.
  2. owner==DBG & dbg_req & (!cpu_req | burst_cnt < BURST_MAX-1) → stay DBG, burst_cnt+1.
  3. dbg_req & (!cpu_req | wait_cnt == WAIT_MAX) → owner=DBG, burst_cnt=0.
  4. Otherwise → owner=CPU (park), burst_cnt=0.
- halted clears at the first edge where dbg_halt=0; owner is then chosen by rules 2–4 at that same edge.
- wait_cnt:
  - Increments at an edge where dbg_waiting=1, saturating at WAIT_MAX.
  - Clears at an edge where dbg_gnt=1 or dbg_req=0.
- burst_cnt saturates at 7; it is never compared when cpu_req=0.

## Timing
- CPU access latency is 0 cycles while parked (the common case). When it is displaced, cpu_gnt returns on the cycle after debug releases the memory, or after the burst limit.
- Debug latency:
  - 1 cycle when the CPU is idle.
  - WAIT_MAX+1 cycles under continuous cpu_req.
- Write: memory captures on the rising edge ending the grant cycle. Requesters hold req/addr/data until they see gnt high at an edge.
- Read: memory data for the granted address is valid in the grant cycle; the top level routes it to both requesters.
- Under continuous cpu_req and dbg_req: DBG gets BURST_MAX cycles, then CPU runs until debug starvation reaches WAIT_MAX again.
- dbg_halt:
  - Asserted in cycle n: cpu_ce=0 from cycle n+1.
  - Deasserted in cycle m: cpu_ce may return in cycle m+1.
- Reset asserted mid-access aborts it: outputs go to reset values immediately (asynchronous); no partial write.

## Test plan
- Reset, then cpu_req=1 with cpu_addr=0x10 and dbg_req=0 → cpu_gnt=1 and cpu_ce=1 in the first cycle after reset release; arb_status=4'b0010.
- cpu_req held at 1; dbg_req raised in cycle 0 with dbg_we=1, addr 0x20, data 0xBEEF → dbg_gnt first high in cycle 5 with mem_we=1 and mem_addr=0x20; cpu_ce=0 for cycles 5–6; CPU regains the memory in cycle 7.
- cpu_req=0, dbg_req=1 for 10 cycles → dbg_gnt high from cycle 1 through cycle 10; no burst cutoff.
- dbg_halt pulsed for 6 cycles with cpu_req=1 → cpu_ce=0 for 6 cycles; arb_status[3]=1; CPU grant resumes the cycle after release.
- Reset asserted during a debug write grant → mem_we, dbg_gnt and cpu_ce are 0 immediately; after release, owner=CPU and the counters are 0.
- Simultaneous dbg_halt=1 and reset release with cpu_req=1 → first post-reset cycle is CPU-owned; from the next cycle owner=DBG and cpu_ce=0.
